// File: rtl/pipe_stage_elastic_if.sv
// rtl/pipe_stage_elastic_if.sv - handshake bundle between a pipeline stage and its neighbours
interface pipe_stage_elastic_if #(
    parameter int DATA_W = 108
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic RV32I stage register, valid/ready, flush, optional 2-entry skid
module pipe_stage_elastic #(
    parameter int DATA_W = 108,
    parameter int CTRL_W = 4,
    parameter int SKID   = 1
) (
    input logic                 clk,
    input logic                 rst,
    pipe_stage_elastic_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKIDF = 2'd2
    } state_t;

    // Keeps the data fields and zeroes the control fields, so a bubble reads as a NOP.
    function automatic logic [DATA_W-1:0] dataMask();
        logic [DATA_W-1:0] m;
        for (int i = 0; i < DATA_W; i++) begin
            m[i] = (i >= CTRL_W);
        end
        return m;
    endfunction

    localparam logic [DATA_W-1:0] KEEP_MASK = dataMask();

    state_t            state;
    logic [DATA_W-1:0] mainReg;
    logic [DATA_W-1:0] skidReg;
    logic              inReady;
    logic              xferIn;
    logic              xferOut;

    always_comb begin
        if (SKID != 0) begin
            inReady = (state != SKIDF);
        end else begin
            inReady = (state == EMPTY) || bus.out_ready;
        end
    end

    assign xferIn  = bus.in_valid && inReady;
    assign xferOut = (state != EMPTY) && bus.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= EMPTY;
            mainReg <= '0;
            skidReg <= '0;
        end else if (bus.flush) begin
            state   <= EMPTY;
            mainReg <= mainReg & KEEP_MASK;
        end else begin
            case (state)
                EMPTY: begin
                    if (xferIn) begin
                        state   <= FULL;
                        mainReg <= bus.in_data;
                    end
                end
                FULL: begin
                    if (xferIn && xferOut) begin
                        mainReg <= bus.in_data;
                    end else if (xferIn) begin
                        // Unreachable without a skid: in FULL, in_ready then implies out_ready.
                        state   <= SKIDF;
                        skidReg <= bus.in_data;
                    end else if (xferOut) begin
                        state   <= EMPTY;
                        mainReg <= mainReg & KEEP_MASK;
                    end
                end
                SKIDF: begin
                    if (xferOut) begin
                        state   <= FULL;
                        mainReg <= skidReg;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    mainReg <= mainReg & KEEP_MASK;
                end
            endcase
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = (state != EMPTY);
    assign bus.out_data  = mainReg;
    assign bus.count     = state;
endmodule
